fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage directly downstream of the program counter. It takes the current PC, drives the instruction-memory address, and computes the next PC fed back to the program counter's input. It also owns the IF/ID pipeline register, including stall, branch/jump redirect flush and halt detection. A perf counter tracks accepted instructions.

## Interface
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that halts fetch.
- `NOP_WORD`, default 32'h0000_0000: encoding loaded into IF/ID on a bubble.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  32  current PC from program counter output.
- `imem_rdata`  in  32  instruction word at `imem_addr`, combinational read.
- `stall`  in  1  hazard unit: hold IF/ID and PC.
- `redirect`  in  1  taken branch or jump resolved downstream.
- `redirect_target`  in  32  PC to fetch after redirect.
- `imem_addr`  out  32  equals `pc`, combinational.
- `pc_next`  out  32  next PC to program counter input, combinational.
- `ifid_pc`  out  32  PC of instruction in IF/ID.
- `ifid_instr`  out  32  instruction in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch halted.
- `fetch_count`  out  32  accepted-instruction counter.

## Operation
- Word-addressed instruction memory: sequential next PC is `pc + 1`, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
- States: RUN, HALTED. Reset -> RUN.
- `pc_next` priority:
  1. `redirect` -> `redirect_target`, in any state, even with `stall` high.
  2. HALTED or `stall` -> `pc`.
  3. Otherwise -> `pc + 1`.
- IF/ID update at rising edge, same priority:
  - `reset`: `ifid_pc`=0, `ifid_instr`=`NOP_WORD`, `ifid_valid`=0, `fetch_count`=0, state RUN.
  - `redirect`: flush. `ifid_instr`=`NOP_WORD`, `ifid_valid`=0, `ifid_pc`=0. If HALTED, go to RUN (the halt was wrong-path).
  - `stall` (no redirect): all IF/ID fields and state hold.
  - HALTED (no redirect): IF/ID loads bubble (`NOP_WORD`, valid 0).
  - RUN accept: `ifid_pc`=`pc`, `ifid_instr`=`imem_rdata`, `ifid_valid`=1, `fetch_count`+1 (wraps).
    - If `imem_rdata`==`HALT_WORD`, the halt word is still latched as valid and the state goes to HALTED.
- `halted` = (state == HALTED), registered.
- `fetch_count` increments only on a RUN accept; never on stall, flush or bubble.

## Timing
- IF/ID and state update on the rising edge. The program counter samples `pc_next` on the falling edge. `pc_next` must therefore settle within half a cycle of `pc`, `stall`, `redirect` and state changes.
- Fetch latency: the instruction at `pc` appears in IF/ID one rising edge after being presented (no stall).
- Redirect penalty:
  - Flush on the edge where `redirect` is sampled high.
  - `redirect_target` enters the PC at the following falling edge.
  - Its instruction is valid in IF/ID one rising edge later.
- Reset mid-operation:
  - All outputs above take reset values at the first rising edge with `reset` high.
  - `pc_next` is don't-care during reset; the program counter resets itself to 0.
  - First accept after reset fetches PC 0.
- Simultaneous `stall` + `redirect`: redirect wins, IF/ID is flushed, no count.
- Stall while HALTED: hold. Redirect while HALTED: leave the halt, flush, no count on that edge.

## Test plan
- Reset then free-run, memory returns `0x1000_0000 + addr`, PC 0..3: `ifid_pc` 0,1,2,3 on successive edges; `ifid_instr` 0x1000_0000..0x1000_0003; `fetch_count`=4; `pc_next`=`pc+1`.
- `stall` high 2 cycles at `pc`=5: `pc_next`=5 both cycles; IF/ID holds PC 4; `fetch_count` unchanged. After release, PC 5 is captured.
- `redirect` with target 0x40 while `stall` high at `pc`=8: `pc_next`=0x40; next edge `ifid_valid`=0 with `NOP_WORD`; following accept gives `ifid_pc`=0x40.
- `HALT_WORD` at `pc`=0x10:
  - PC 0x10 latched with valid 1, `halted`=1.
  - `pc_next` stays 0x10.
  - Subsequent IF/ID bubbles; `fetch_count` frozen.
  - `redirect` to 0x20 clears `halted` and fetch resumes at 0x20.
- `pc`=32'hFFFF_FFFF, no stall: `pc_next`=0.
- Assert `reset` mid-run with `fetch_count`=7: next edge gives `fetch_count`=0, `ifid_valid`=0, `halted`=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: PC in, instruction memory
// read port, hazard/redirect controls in, next PC and IF/ID contents out.
interface fetch_stage_if;
    logic [31:0] pc;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] pc_next;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    // Fetch-stage side.
    modport master (
        input  pc, imem_rdata, stall, redirect, redirect_target,
        output imem_addr, pc_next, ifid_pc, ifid_instr, ifid_valid,
               halted, fetch_count
    );

    // Environment side: program counter, memory, hazard unit, decode.
    modport slave (
        output pc, imem_rdata, stall, redirect, redirect_target,
        input  imem_addr, pc_next, ifid_pc, ifid_instr, ifid_valid,
               halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address, computes
// the next PC for the program counter, and owns the IF/ID register with
// stall, redirect flush, halt detection and an accepted-instruction counter.
module fetch_stage #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_accept;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    // Next PC and next state; redirect overrides both stall and halt.
    always_comb begin
        w_pc_next    = bus.pc + 32'd1;
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (bus.redirect) begin
            w_pc_next    = bus.redirect_target;
            w_state_next = S_RUN;
        end else if (bus.stall) begin
            w_pc_next    = bus.pc;
        end else if (r_state == S_HALTED) begin
            w_pc_next    = bus.pc;
        end else begin
            w_accept = 1'b1;
            if (bus.imem_rdata == HALT_WORD) begin
                w_state_next = S_HALTED;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // IF/ID register: flush on redirect, hold on stall, bubble while halted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
        end else if (bus.redirect) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
        end else if (bus.stall) begin
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_instr <= r_ifid_instr;
            r_ifid_valid <= r_ifid_valid;
        end else if (r_state == S_HALTED) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_pc    <= bus.pc;
            r_ifid_instr <= bus.imem_rdata;
            r_ifid_valid <= 1'b1;
        end
    end

    // Accepted-instruction counter, wraps modulo 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.imem_addr   = bus.pc;
    assign bus.pc_next     = w_pc_next;
    assign bus.ifid_pc     = r_ifid_pc;
    assign bus.ifid_instr  = r_ifid_instr;
    assign bus.ifid_valid  = r_ifid_valid;
    assign bus.halted      = (r_state == S_HALTED);
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The bench plays the program counter by
// presenting a PC after each falling edge; memory returns 0x1000_0000 + addr
// except at 0x10, which holds the halt word.
module tb_fetch_stage;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .HALT_WORD (32'hFFFF_FFFF),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h10) return 32'hFFFF_FFFF;
        return 32'h1000_0000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present inputs after the falling edge, let combinational outputs settle.
    task automatic drive(input logic [31:0] p, input logic s, input logic r, input logic [31:0] t);
        @(negedge clock);
        bus.pc              = p;
        bus.imem_rdata      = mem(p);
        bus.stall           = s;
        bus.redirect        = r;
        bus.redirect_target = t;
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] p, input logic [31:0] ins,
                              input logic v, input logic [31:0] cnt);
        check({tag, ".ifid_pc"}, bus.ifid_pc, p);
        check({tag, ".ifid_instr"}, bus.ifid_instr, ins);
        check({tag, ".ifid_valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
        check({tag, ".fetch_count"}, bus.fetch_count, cnt);
    endtask

    initial begin
        bus.pc = '0; bus.imem_rdata = '0; bus.stall = 1'b0;
        bus.redirect = 1'b0; bus.redirect_target = '0;

        // Reset values
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'd0);
        check("rst.halted", {31'd0, bus.halted}, 32'd0);
        reset = 1'b0;

        // Free run PC 0..3
        for (int unsigned i = 0; i < 4; i++) begin
            drive(i, 1'b0, 1'b0, 32'h0);
            check("run.pc_next", bus.pc_next, i + 1);
            check("run.imem_addr", bus.imem_addr, i);
            edge_sample();
            check_ifid("run", i, 32'h1000_0000 + i, 1'b1, i + 1);
        end

        // PC 4 accept, then stall two cycles at PC 5
        drive(32'h4, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check_ifid("pc4", 32'h4, 32'h1000_0004, 1'b1, 32'd5);
        for (int unsigned i = 0; i < 2; i++) begin
            drive(32'h5, 1'b1, 1'b0, 32'h0);
            check("stall.pc_next", bus.pc_next, 32'h5);
            edge_sample();
            check_ifid("stall", 32'h4, 32'h1000_0004, 1'b1, 32'd5);
        end
        drive(32'h5, 1'b0, 1'b0, 32'h0);
        check("unstall.pc_next", bus.pc_next, 32'h6);
        edge_sample();
        check_ifid("unstall", 32'h5, 32'h1000_0005, 1'b1, 32'd6);

        drive(32'h6, 1'b0, 1'b0, 32'h0);
        edge_sample();
        drive(32'h7, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check("pc7.count", bus.fetch_count, 32'd8);

        // Redirect to 0x40 with stall high at PC 8
        drive(32'h8, 1'b1, 1'b1, 32'h40);
        check("redir.pc_next", bus.pc_next, 32'h40);
        edge_sample();
        check_ifid("redir", 32'h0, 32'h0, 1'b0, 32'd8);
        drive(32'h40, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check_ifid("tgt", 32'h40, 32'h1000_0040, 1'b1, 32'd9);

        // Jump to 0x10 where the halt word lives
        drive(32'h41, 1'b0, 1'b1, 32'h10);
        edge_sample();
        check_ifid("j10", 32'h0, 32'h0, 1'b0, 32'd9);
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        check("prehalt.pc_next", bus.pc_next, 32'h11);
        edge_sample();
        check_ifid("halt", 32'h10, 32'hFFFF_FFFF, 1'b1, 32'd10);
        check("halt.halted", {31'd0, bus.halted}, 32'd1);
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        check("halted.pc_next", bus.pc_next, 32'h10);
        edge_sample();
        check("bubble.valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("bubble.instr", bus.ifid_instr, 32'h0);
        check("bubble.count", bus.fetch_count, 32'd10);
        check("bubble.halted", {31'd0, bus.halted}, 32'd1);
        drive(32'h10, 1'b1, 1'b0, 32'h0);
        edge_sample();
        check("hstall.halted", {31'd0, bus.halted}, 32'd1);
        check("hstall.count", bus.fetch_count, 32'd10);

        // Redirect out of halt
        drive(32'h10, 1'b0, 1'b1, 32'h20);
        check("unhalt.pc_next", bus.pc_next, 32'h20);
        edge_sample();
        check("unhalt.halted", {31'd0, bus.halted}, 32'd0);
        check_ifid("unhalt", 32'h0, 32'h0, 1'b0, 32'd10);
        drive(32'h20, 1'b0, 1'b0, 32'h0);
        check("resume.pc_next", bus.pc_next, 32'h21);
        edge_sample();
        check_ifid("resume", 32'h20, 32'h1000_0020, 1'b1, 32'd11);

        // PC wrap
        drive(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        check("wrap.pc_next", bus.pc_next, 32'h0);
        edge_sample();
        check_ifid("wrap", 32'hFFFF_FFFF, 32'h0FFF_FFFF, 1'b1, 32'd12);

        // Mid-run reset with fetch_count 7 and fetch halted
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        edge_sample();
        reset = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            drive(i, 1'b0, 1'b0, 32'h0);
            edge_sample();
        end
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check("pre.count", bus.fetch_count, 32'd7);
        check("pre.halted", {31'd0, bus.halted}, 32'd1);
        reset = 1'b1;
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check_ifid("midrst", 32'h0, 32'h0, 1'b0, 32'd0);
        check("midrst.halted", {31'd0, bus.halted}, 32'd0);
        reset = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        edge_sample();
        check_ifid("postrst", 32'h0, 32'h1000_0000, 1'b1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
